// File: rtl/meta_streamer.sv
// meta_streamer
//    Streams a fixed device-metadata record (name, firmware version, memory
//    size, maximum sample rate, probe count, protocol version) one byte at a
//    time to a byte transmitter. Each byte is presented as a one-cycle strobe.
//    After every byte the streamer waits for the transmitter to report idle
//    before it sends the next one.
//
//    Optional feature: define META_DYNMEM_EN to insert the dynamic-memory
//    token (0x22 + DYN_MEM_BYTES, big-endian) after the memory-size token.
//
// Ports
//    clock           in   single clock, rising edge
//    extReset        in   synchronous active-high reset
//    query_metadata  in   start request (level-sampled while idle)
//    abort           in   terminate the stream in progress
//    xmit_idle       in   transmitter can accept a byte
//    writeMeta       out  one-cycle byte strobe
//    meta_data       out  byte, valid while writeMeta=1
//    meta_busy       out  high whenever a stream is in progress
//    meta_done       out  one-cycle pulse on normal completion
module meta_streamer #(
   parameter logic [8*24-1:0] NAME          = "Pipistrello OLS",
   parameter int              NAME_LEN      = 15,
   parameter logic [8*8-1:0]  FW_VER        = "3.07",
   parameter int              FW_LEN        = 4,
   parameter logic [31:0]     MEM_BYTES     = 32'h04000000,
   parameter logic [31:0]     MAX_RATE      = 32'd200000000,
   parameter logic [7:0]      PROBES        = 8'd32,
   parameter logic [7:0]      PROTO         = 8'd2,
   parameter logic [31:0]     DYN_MEM_BYTES = 32'h00000000
) (
   input  logic       clock,
   input  logic       extReset,
   input  logic       query_metadata,
   input  logic       abort,
   input  logic       xmit_idle,
   output logic       writeMeta,
   output logic [7:0] meta_data,
   output logic       meta_busy,
   output logic       meta_done
);

`ifdef META_DYNMEM_EN
   localparam int DYN_LEN = 5;
`else
   localparam int DYN_LEN = 0;
`endif

   // Byte positions of the record fields.
   localparam int NAME_END = NAME_LEN + 1;         // name terminator
   localparam int FW_TOK   = NAME_LEN + 2;         // 0x02
   localparam int FW_END   = FW_TOK + FW_LEN + 1;  // firmware terminator
   localparam int MEM_TOK  = FW_END + 1;           // 0x21
   localparam int DYN_TOK  = MEM_TOK + 5;          // 0x22 (only when enabled)
   localparam int RATE_TOK = DYN_TOK + DYN_LEN;    // 0x23
   localparam int L        = RATE_TOK + 10;        // total record length
   localparam int IW       = $clog2(L + 1);

   localparam logic [IW-1:0] L_IDX = IW'(L);
   localparam logic [IW-1:0] ONE   = IW'(1);

   // Strings are right-justified in their vectors, so the first character
   // of an n-char string sits at byte n-1; shifts keep the dead branches
   // of this elaboration-time function free of out-of-range selects.
   function automatic logic [7:0] byte_at(input int i);
      logic [7:0] b;
      b = 8'h00;
      if (i == 0)
         b = 8'h01;
      else if (i < NAME_END)
         b = 8'(NAME >> (8 * (NAME_LEN - i)));
      else if (i == NAME_END)
         b = 8'h00;
      else if (i == FW_TOK)
         b = 8'h02;
      else if (i < FW_END)
         b = 8'(FW_VER >> (8 * (FW_END - 1 - i)));
      else if (i == FW_END)
         b = 8'h00;
      else if (i == MEM_TOK)
         b = 8'h21;
      else if (i < DYN_TOK)
         b = 8'(MEM_BYTES >> (8 * (DYN_TOK - 1 - i)));
      else if (i < RATE_TOK) begin
         if (i == DYN_TOK)
            b = 8'h22;
         else
            b = 8'(DYN_MEM_BYTES >> (8 * (RATE_TOK - 1 - i)));
      end
      else if (i == RATE_TOK)
         b = 8'h23;
      else if (i < RATE_TOK + 5)
         b = 8'(MAX_RATE >> (8 * (RATE_TOK + 4 - i)));
      else if (i == RATE_TOK + 5)
         b = 8'h40;
      else if (i == RATE_TOK + 6)
         b = PROBES;
      else if (i == RATE_TOK + 7)
         b = 8'h41;
      else if (i == RATE_TOK + 8)
         b = PROTO;
      else
         b = 8'h00;
      return b;
   endfunction

   // Constant record table, one entry per byte.
   logic [7:0] rom [0:L-1];

   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_rom
         assign rom[gi] = byte_at(gi);
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GUARD,
      POLL
   } state_t;

   state_t          state_reg;
   logic [IW-1:0]   idx_reg;
   logic            write_reg;
   logic [7:0]      data_reg;
   logic            done_reg;

   // Outputs are registered on the transition into SEND, so the strobe is
   // visible during the SEND cycle itself. idx_reg always holds the index of
   // the next byte to send.
   always_ff @(posedge clock) begin
      if (extReset) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         write_reg <= 1'b0;
         data_reg  <= 8'h00;
         done_reg  <= 1'b0;
      end else begin
         write_reg <= 1'b0;
         done_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               idx_reg <= '0;
               if (query_metadata && xmit_idle && !abort) begin
                  state_reg <= SEND;
                  write_reg <= 1'b1;
                  data_reg  <= rom[0];
                  idx_reg   <= ONE;
               end
            end
            SEND: begin
               state_reg <= abort ? IDLE : GUARD;
            end
            // Transmitter idle flag may lag our strobe by a cycle; skip it.
            GUARD: begin
               state_reg <= abort ? IDLE : POLL;
            end
            POLL: begin
               if (abort) begin
                  state_reg <= IDLE;
               end else if (xmit_idle) begin
                  if (idx_reg < L_IDX) begin
                     state_reg <= SEND;
                     write_reg <= 1'b1;
                     data_reg  <= rom[idx_reg];
                     idx_reg   <= idx_reg + ONE;
                  end else begin
                     state_reg <= IDLE;
                     done_reg  <= 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign writeMeta = write_reg;
   assign meta_data = data_reg;
   assign meta_done = done_reg;
   assign meta_busy = (state_reg != IDLE);

endmodule

// File: tb/tb_meta_streamer.sv
// tb_meta_streamer
//    Directed bench for meta_streamer configured with NAME="Test",
//    FW_VER="1.0". Expected bytes and strobe spacing are queued when a
//    stream is requested; a negedge monitor pops and compares every strobe.
//    Builds with or without META_DYNMEM_EN.
module tb_meta_streamer;

   logic       clock = 1'b0;
   logic       extReset;
   logic       query_metadata;
   logic       abort;
   logic       xmit_idle;
   logic       writeMeta;
   logic [7:0] meta_data;
   logic       meta_busy;
   logic       meta_done;

   meta_streamer #(
      .NAME          ("Test"),
      .NAME_LEN      (4),
      .FW_VER        ("1.0"),
      .FW_LEN        (3),
      .DYN_MEM_BYTES (32'h00100000)
   ) dut (
      .clock          (clock),
      .extReset       (extReset),
      .query_metadata (query_metadata),
      .abort          (abort),
      .xmit_idle      (xmit_idle),
      .writeMeta      (writeMeta),
      .meta_data      (meta_data),
      .meta_busy      (meta_busy),
      .meta_done      (meta_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0] d;
      int         gap;      // required cycles since previous strobe, -1 = skip
      int         abs_cyc;  // required absolute cycle, -1 = skip
   } exp_t;

   exp_t       sb [$];
   logic [7:0] stream [$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         last_stb = 0;
   int         stb_cnt = 0;
   int         done_cnt = 0;
   int         slen;

   always @(posedge clock) cyc++;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: one line per strobe, compares against the scoreboard head.
   always @(negedge clock) begin
      exp_t e;
      if (writeMeta) begin
         stb_cnt++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe actual=%02h required=none (cycle %0d)", meta_data, cyc);
         end else begin
            e = sb.pop_front();
            $display("strobe %0d cycle %0d data=%02h expect=%02h", stb_cnt, cyc, meta_data, e.d);
            check("byte", int'(meta_data), int'(e.d));
            if (e.gap >= 0) check("spacing", cyc - last_stb, e.gap);
            if (e.abs_cyc >= 0) check("first_latency", cyc, e.abs_cyc);
         end
         last_stb = cyc;
      end
      if (meta_done) done_cnt++;
   end

   // Every stimulus action happens 1 time unit after a falling edge.
   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic push_stream(input int n, input int first_abs, input int first_gap,
                              input int stall_at, input int stall_gap);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.d       = stream[i];
         e.abs_cyc = (i == 0) ? first_abs : -1;
         e.gap     = (i == 0) ? first_gap : ((i == stall_at) ? stall_gap : 3);
         sb.push_back(e);
      end
   endtask

   task automatic start_stream(input int n, input int stall_at, input int stall_gap);
      query_metadata = 1'b1;
      push_stream(n, cyc + 1, -1, stall_at, stall_gap);
      step();
      query_metadata = 1'b0;
   endtask

   // Return while the target-th strobe (absolute count) is on the outputs.
   task automatic wait_strobe(input int target);
      for (int k = 0; k < 400; k++) begin
         if (writeMeta && stb_cnt == target) return;
         step();
      end
      check("strobe_timeout", stb_cnt, target);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 400; k++) begin
         if (sb.size() == 0) return;
         step();
      end
      check("drain_timeout", sb.size(), 0);
      sb.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_writeMeta"}, int'(writeMeta), 0);
      check({tag, "_meta_data"}, int'(meta_data), 0);
      check({tag, "_meta_busy"}, int'(meta_busy), 0);
      check({tag, "_meta_done"}, int'(meta_done), 0);
   endtask

   initial begin
      int base;
      int d0;
`ifdef META_DYNMEM_EN
      stream = '{8'h01, 8'h54, 8'h65, 8'h73, 8'h74, 8'h00, 8'h02, 8'h31, 8'h2E, 8'h30, 8'h00,
                 8'h21, 8'h04, 8'h00, 8'h00, 8'h00, 8'h22, 8'h00, 8'h10, 8'h00, 8'h00,
                 8'h23, 8'h0B, 8'hEB, 8'hC2, 8'h00, 8'h40, 8'h20, 8'h41, 8'h02, 8'h00};
`else
      stream = '{8'h01, 8'h54, 8'h65, 8'h73, 8'h74, 8'h00, 8'h02, 8'h31, 8'h2E, 8'h30, 8'h00,
                 8'h21, 8'h04, 8'h00, 8'h00, 8'h00,
                 8'h23, 8'h0B, 8'hEB, 8'hC2, 8'h00, 8'h40, 8'h20, 8'h41, 8'h02, 8'h00};
`endif
      slen = stream.size();

      extReset       = 1'b1;
      query_metadata = 1'b0;
      abort          = 1'b0;
      xmit_idle      = 1'b1;
      repeat (3) step();
      check_all_zero("reset");
      extReset = 1'b0;
      repeat (2) step();

      // Full stream with a single query pulse.
      d0 = done_cnt;
      start_stream(slen, -1, 0);
      wait_drain();
      repeat (5) step();
      check("full_done", done_cnt - d0, 1);
      check("full_busy", int'(meta_busy), 0);

      // Transmitter stalls for 10 cycles after the 3rd byte.
      d0 = done_cnt;
      base = stb_cnt;
      start_stream(slen, 3, 11);
      wait_strobe(base + 3);
      xmit_idle = 1'b0;
      repeat (10) step();
      xmit_idle = 1'b1;
      wait_drain();
      repeat (5) step();
      check("stall_done", done_cnt - d0, 1);

      // Abort in the cycle after the 5th byte.
      d0 = done_cnt;
      base = stb_cnt;
      start_stream(5, -1, 0);
      wait_strobe(base + 5);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy", int'(meta_busy), 0);
      repeat (10) step();
      check("abort_done", done_cnt - d0, 0);
      check("abort_leftover", sb.size(), 0);
      start_stream(slen, -1, 0);
      wait_drain();
      repeat (5) step();
      check("restart_done", done_cnt - d0, 1);

      // Abort in the final POLL beats normal completion.
      d0 = done_cnt;
      base = stb_cnt;
      start_stream(slen, -1, 0);
      wait_strobe(base + slen);
      step();
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("final_abort_busy", int'(meta_busy), 0);
      repeat (5) step();
      check("final_abort_done", done_cnt - d0, 0);

      // Reset during POLL after the 10th byte.
      d0 = done_cnt;
      base = stb_cnt;
      start_stream(10, -1, 0);
      wait_strobe(base + 10);
      step();
      step();
      extReset = 1'b1;
      step();
      extReset = 1'b0;
      check_all_zero("midreset");
      repeat (5) step();
      check("midreset_leftover", sb.size(), 0);
      start_stream(slen, -1, 0);
      wait_drain();
      repeat (5) step();
      check("midreset_done", done_cnt - d0, 1);

      // Query ignored while transmitter busy, and while abort is high.
      xmit_idle = 1'b0;
      query_metadata = 1'b1;
      repeat (5) begin
         step();
         check("noidle_busy", int'(meta_busy), 0);
      end
      xmit_idle = 1'b1;
      abort = 1'b1;
      repeat (5) begin
         step();
         check("qabort_busy", int'(meta_busy), 0);
      end
      query_metadata = 1'b0;
      abort = 1'b0;
      repeat (3) step();

      // Query held high: stream restarts from byte 0 after completion.
      d0 = done_cnt;
      base = stb_cnt;
      query_metadata = 1'b1;
      push_stream(slen, cyc + 1, -1, -1, 0);
      push_stream(slen, -1, 4, -1, 0);
      wait_strobe(base + slen + 1);
      query_metadata = 1'b0;
      wait_drain();
      repeat (5) step();
      check("held_done", done_cnt - d0, 2);
      check("final_busy", int'(meta_busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
